program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 21 ++
 rtl/program_loader_byte_packer.sv | 49 ++++
 rtl/program_loader.sv | 131 +++++++++++++
 tb/tb_program_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: loader FSM state encoding and
// the instruction-memory / word-count geometry.
package loader_pkg;

    localparam int IMEM_ADDR_W = 10;    // instruction memory word address width
    localparam int MAX_WORDS   = 1024;  // largest legal program, in words
    localparam int COUNT_W     = 11;    // wide enough to hold MAX_WORDS itself
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer: assembles big-endian 32-bit words from a byte stream.
//   i_clk        : clock
//   i_rst_n      : synchronous active-low reset (clears everything)
//   i_clr        : restart word alignment for a new load (word output kept)
//   i_shift      : accept i_byte this cycle
//   i_byte       : incoming byte, first byte of a word lands in [31:24]
//   o_word       : last completed word; holds until the next word completes
//   o_word_ready : this cycle's shift completes a word (combinational)
module byte_packer
    import loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_shift,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_ready
);

    // The first three bytes are staged; the fourth goes straight into the
    // output word, so the word is visible the cycle after its last byte.
    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [1:0]               r_cnt;
    logic [WORD_W-1:0]        r_word;

    assign o_word_ready = i_shift && (r_cnt == 2'd3);
    assign o_word       = r_word;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
        end else if (i_clr) begin
            // r_word is left alone: it drives the memory data bus, which
            // must not change outside a write.
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
            if (o_word_ready) begin
                r_word <= {r_shift, i_byte};
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream and writes it into
// instruction memory, holding the CPU until the load completes.
//   i_clock        : system clock
//   i_reset        : synchronous active-low reset
//   i_start        : one-cycle pulse, starts a load from IDLE or DONE
//   i_rx_data      : stream byte; i_rx_valid qualifies it
//   o_rx_ready     : byte accepted when i_rx_valid && o_rx_ready
//   o_imem_we/addr/wdata : instruction memory write port, one strobe per word
//   o_cpu_hold     : low only once a load has completed
//   o_done         : load complete (level until next start/reset)
//   o_error        : word count above MAX_WORDS (level until reset)
//   o_words_loaded : words written in the current load
// All outputs are registered, decoded from the next state.
module program_loader
    import loader_pkg::*;
(
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic                   o_rx_ready,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [31:0]            o_imem_wdata,
    output logic                   o_cpu_hold,
    output logic                   o_done,
    output logic                   o_error,
    output logic [COUNT_W-1:0]     o_words_loaded
);

    state_t                 r_state, w_state_nxt;
    logic [COUNT_W-1:0]     r_count, r_words, w_words_inc, w_count_full;
    logic [IMEM_ADDR_W-1:0] r_addr;
    logic                   r_rx_ready, r_imem_we, r_cpu_hold, r_done, r_error;
    logic                   w_rx_ready_nxt, w_imem_we_nxt, w_cpu_hold_nxt;
    logic                   w_done_nxt, w_error_nxt;
    logic                   w_accept, w_start_ld, w_shift, w_word_ready;
    logic [WORD_W-1:0]      w_word;

    assign w_accept     = i_rx_valid && r_rx_ready;
    assign w_shift      = w_accept && (r_state == S_DATA);
    assign w_words_inc  = r_words + COUNT_W'(1);
    // Full count as it will be once the low byte is taken this cycle.
    assign w_count_full = {r_count[COUNT_W-1:8], i_rx_data};

    byte_packer u_packer (
        .i_clk        (i_clock),
        .i_rst_n      (i_reset),
        .i_clr        (w_start_ld),
        .i_shift      (w_shift),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start_ld  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_CNT_HI;
                    w_start_ld  = 1'b1;
                end
            end
            S_CNT_HI: if (w_accept) w_state_nxt = S_CNT_LO;
            S_CNT_LO: begin
                if (w_accept) begin
                    if (w_count_full == '0)
                        w_state_nxt = S_DONE;
                    else if (w_count_full > COUNT_W'(MAX_WORDS))
                        w_state_nxt = S_ERROR;
                    else
                        w_state_nxt = S_DATA;
                end
            end
            S_DATA:  if (w_word_ready) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = (w_words_inc == r_count) ? S_DONE : S_DATA;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_IDLE;
        endcase

        w_rx_ready_nxt = (w_state_nxt == S_CNT_HI) || (w_state_nxt == S_CNT_LO) ||
                         (w_state_nxt == S_DATA);
        w_imem_we_nxt  = (w_state_nxt == S_WRITE);
        w_cpu_hold_nxt = (w_state_nxt != S_DONE);
        w_done_nxt     = (w_state_nxt == S_DONE);
        w_error_nxt    = (w_state_nxt == S_ERROR);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_words    <= '0;
            r_addr     <= '0;
            r_rx_ready <= 1'b0;
            r_imem_we  <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= w_rx_ready_nxt;
            r_imem_we  <= w_imem_we_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            if (w_start_ld) begin
                r_count <= '0;
                r_words <= '0;
            end
            if (w_accept && r_state == S_CNT_HI) r_count[COUNT_W-1:8] <= i_rx_data[2:0];
            if (w_accept && r_state == S_CNT_LO) r_count[7:0] <= i_rx_data;
            if (r_state == S_WRITE) r_words <= w_words_inc;
            // Address is the pre-increment word count, latched entering WRITE.
            if (w_state_nxt == S_WRITE) r_addr <= r_words[IMEM_ADDR_W-1:0];
        end
    end

    assign o_rx_ready     = r_rx_ready;
    assign o_imem_we      = r_imem_we;
    assign o_imem_addr    = r_addr;
    assign o_imem_wdata   = w_word;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a table of count headers with
// expected end states, hand-written corner sequences, and randomized loads
// checked against a stream-level model of the expected memory writes.
`timescale 1ns/1ps
module tb_program_loader;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, imem_we, cpu_hold, done, error;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] words_loaded;

    always #5 clk = ~clk;

    program_loader dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_start        (start),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .o_rx_ready     (rx_ready),
        .o_imem_we      (imem_we),
        .o_imem_addr    (imem_addr),
        .o_imem_wdata   (imem_wdata),
        .o_cpu_hold     (cpu_hold),
        .o_done         (done),
        .o_error        (error),
        .o_words_loaded (words_loaded)
    );

    typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
    typedef struct {
        logic [7:0]  b0, b1;
        bit          gaps;
        logic        done, err, hold, rdy;
        logic [10:0] words;
    } vec_t;

    wr_t        wr_q[$];
    wr_t        exp_q[$];
    logic [7:0] stream[$];
    int         n_tests = 0, n_fail = 0;
    int         bad_ready = 0, bad_hold = 0;
    logic [9:0]  last_a = '0;
    logic [31:0] last_d = '0;

    // Write capture plus continuous checks: no rx_ready during a write, and
    // the memory address/data buses stay still outside a write.
    always @(negedge clk) begin
        if (rst_n && imem_we) wr_q.push_back({imem_addr, imem_wdata});
        if (imem_we && rx_ready) bad_ready++;
        if (rst_n && !imem_we && (imem_addr !== last_a || imem_wdata !== last_d)) bad_hold++;
        last_a = imem_addr;
        last_d = imem_wdata;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        wr_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk(name, 64'({rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error, words_loaded}),
            64'({1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0}));
    endtask

    // Offer one byte; optional random idle gaps first (data is junk then).
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0; rx_data = 8'($urandom);
                tick();
            end
        end
        rx_valid = 1'b1; rx_data = b;
        while (!rx_ready && n < 20) begin tick(); n++; end
        if (!rx_ready) begin
            chk("rx_ready wait", 64'(rx_ready), 64'(1));
        end else begin
            tick();
        end
        rx_valid = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi && i < stream.size(); i++) send_byte(stream[i], gaps);
    endtask

    task automatic gen_stream(input logic [7:0] b0, input logic [7:0] b1);
        int c;
        stream.delete();
        stream.push_back(b0);
        stream.push_back(b1);
        c = (int'(b0) % 8) * 256 + int'(b1);
        if (c <= 1024) for (int i = 0; i < 4 * c; i++) stream.push_back(8'($urandom));
    endtask

    // Expected writes from the stream: one per complete big-endian word
    // present, at consecutive addresses, up to the header count.
    task automatic build_model(output int cnt, output bit err);
        exp_q.delete();
        cnt = (int'(stream[0]) % 8) * 256 + int'(stream[1]);
        err = (cnt > 1024);
        if (!err)
            for (int i = 0; i < cnt && 4 * i + 5 < stream.size(); i++)
                exp_q.push_back({10'(i), stream[4*i+2], stream[4*i+3], stream[4*i+4], stream[4*i+5]});
    endtask

    task automatic compare_writes(input string name);
        chk({name, " write count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk({name, " write"}, 64'(wr_q[i]), 64'(exp_q[i]));
        wr_q.delete();
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 20) begin tick(); n++; end
        chk("load completion", 64'(done || error), 64'(1));
    endtask

    vec_t vt [0:6];

    initial begin
        int cnt;
        bit err;
        vt[0] = '{8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd2};
        vt[1] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
        vt[2] = '{8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1};
        vt[3] = '{8'hF8, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd3};
        vt[4] = '{8'h04, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'd0};
        vt[5] = '{8'h07, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'd0};
        vt[6] = '{8'h00, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5};

        // Reset values while reset is held.
        rst_n = 1'b0;
        tick(); tick();
        chk_idle("reset values");
        rst_n = 1'b1;
        tick();
        chk_idle("idle before start");

        // Table: header -> end state and model writes.
        for (int k = 0; k < 7; k++) begin
            do_reset();
            pulse_start();
            gen_stream(vt[k].b0, vt[k].b1);
            build_model(cnt, err);
            send_range(0, stream.size(), vt[k].gaps);
            wait_end();
            chk("tbl done",  64'(done),         64'(vt[k].done));
            chk("tbl error", 64'(error),        64'(vt[k].err));
            chk("tbl hold",  64'(cpu_hold),     64'(vt[k].hold));
            chk("tbl ready", 64'(rx_ready),     64'(vt[k].rdy));
            chk("tbl words", 64'(words_loaded), 64'(vt[k].words));
            compare_writes("tbl");
        end

        // Known two-word program, exact data and write latency.
        do_reset();
        pulse_start();
        chk("start hold/ready/done", 64'({cpu_hold, rx_ready, done}), 64'(3'b110));
        stream = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
        send_range(0, 6, 1'b0);
        chk("write latency we/ready", 64'({imem_we, rx_ready}), 64'(2'b10));
        chk("first write addr/data", 64'({imem_addr, imem_wdata}), 64'({10'd0, 32'h20010005}));
        tick();
        chk("we one cycle, data held", 64'({imem_we, imem_wdata}), 64'({1'b0, 32'h20010005}));
        send_range(6, 10, 1'b0);
        wait_end();
        chk("known done/hold", 64'({done, cpu_hold}), 64'(2'b10));
        chk("known words", 64'(words_loaded), 64'(2));
        exp_q.delete();
        exp_q.push_back({10'd0, 32'h20010005});
        exp_q.push_back({10'd1, 32'hAC010000});
        compare_writes("known");

        // Error state ignores start.
        do_reset();
        pulse_start();
        stream = '{8'h04, 8'h01};
        send_range(0, 2, 1'b0);
        chk("error entry", 64'({error, rx_ready, cpu_hold, done}), 64'(4'b1010));
        pulse_start();
        tick();
        chk("error sticky", 64'({error, rx_ready, cpu_hold, done}), 64'(4'b1010));
        exp_q.delete();
        compare_writes("error");

        // Randomized loads with gaps, chained through DONE without reset.
        do_reset();
        for (int r = 0; r < 6; r++) begin
            int c;
            c = (r == 0) ? 3 : $urandom_range(1, 12);
            pulse_start();
            gen_stream({5'($urandom), 3'(c >> 8)}, 8'(c));
            build_model(cnt, err);
            send_range(0, stream.size(), 1'b1);
            wait_end();
            chk("rand done", 64'({done, error, cpu_hold}), 64'(3'b100));
            chk("rand words", 64'(words_loaded), 64'(cnt));
            compare_writes("rand");
        end

        // Full 1024-word load at one byte per cycle.
        do_reset();
        pulse_start();
        gen_stream(8'h04, 8'h00);
        build_model(cnt, err);
        send_range(0, stream.size(), 1'b0);
        wait_end();
        chk("max words", 64'(words_loaded), 64'(1024));
        chk("max last addr", 64'(imem_addr), 64'(1023));
        compare_writes("max");

        // Reset two bytes into word 5, then a fresh load starts at 0.
        do_reset();
        pulse_start();
        gen_stream(8'h00, 8'h08);
        send_range(0, 24, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_idle("mid-load reset");
        tick();
        rst_n = 1'b1;
        stream = stream[0:23];
        build_model(cnt, err);
        compare_writes("pre-reset");
        pulse_start();
        gen_stream(8'h00, 8'h02);
        build_model(cnt, err);
        send_range(0, stream.size(), 1'b0);
        wait_end();
        compare_writes("after reset");

        // start in DATA is ignored; start in DONE restarts.
        do_reset();
        pulse_start();
        gen_stream(8'h00, 8'h02);
        build_model(cnt, err);
        send_range(0, 5, 1'b0);
        pulse_start();
        chk("start in DATA", 64'({rx_ready, done, cpu_hold, words_loaded}), 64'({1'b1, 1'b0, 1'b1, 11'd0}));
        send_range(5, stream.size(), 1'b0);
        wait_end();
        chk("start in DATA words", 64'(words_loaded), 64'(2));
        compare_writes("start in DATA");
        pulse_start();
        chk("restart from DONE", 64'({cpu_hold, done, rx_ready, words_loaded}), 64'({1'b1, 1'b0, 1'b1, 11'd0}));
        gen_stream(8'h00, 8'h01);
        build_model(cnt, err);
        send_range(0, stream.size(), 1'b1);
        wait_end();
        compare_writes("restart");

        tick();
        chk("rx_ready during write", 64'(bad_ready), 64'(0));
        chk("bus hold outside write", 64'(bad_hold), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
